// File: rtl/sfu_pkg.sv
// Shared definitions for the SFU stream driver: function selects, FSM encoding and Q4.4 constants.
package sfu_pkg;

    localparam int DATA_W = 8;
    localparam int SUM_W  = 16;

    // Q4.4 fixed-point representation of 1.0
    localparam logic signed [DATA_W-1:0] ONE = 8'sd16;

    typedef enum logic [2:0] {
        FN_RELU    = 3'd0,
        FN_SIGMOID = 3'd1,
        FN_GELU    = 3'd2,
        FN_TANH    = 3'd3,
        FN_EXP     = 3'd4,
        FN_RSQRT   = 3'd5,
        FN_IDENT   = 3'd6,
        FN_ABS     = 3'd7
    } func_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOADED = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } drv_state_e;

endpackage

// File: rtl/sfu_vec_buf.sv
// Operand/result register file for the SFU stream driver.
// One write port, one asynchronous read port addressed by an external select.
module sfu_vec_buf
    import sfu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(DEPTH)-1:0]     wr_addr,
    input  logic signed [DATA_W-1:0]     wr_data,
    input  logic [$clog2(DEPTH)-1:0]     rd_sel,
    output logic signed [DATA_W-1:0]     rd_data
);

    logic signed [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_sel];

endmodule

// File: rtl/sfu_stream_driver.sv
// Initiator front-end for the combinational SFU: load a vector, run it through the SFU in place, stream results out.
// Optional accumulator of captured results (sum_out) is built when SFU_ACCUM_EN is defined.
module sfu_stream_driver
    import sfu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [DATA_W-1:0]  in_data,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    input  logic                      cmd_start,
    input  logic [2:0]                cmd_func,
    output logic                      busy,
    output logic signed [DATA_W-1:0]  sfu_x,
    output logic [2:0]                sfu_func,
    input  logic signed [DATA_W-1:0]  sfu_y,
    output logic signed [DATA_W-1:0]  out_data,
    output logic                      out_valid,
    output logic                      out_last,
    input  logic                      out_ready
`ifdef SFU_ACCUM_EN
    ,
    output logic signed [SUM_W-1:0]   sum_out
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    drv_state_e               state;
    logic [CNT_W-1:0]         count;
    logic [CNT_W-1:0]         run_k;
    logic [CNT_W-1:0]         rd;
    logic                     in_acc;
    logic                     buf_we;
    logic [AW-1:0]            buf_wa;
    logic [AW-1:0]            buf_ra;
    logic signed [DATA_W-1:0] buf_wd;
    logic signed [DATA_W-1:0] buf_rd;

    assign in_ready = (state == ST_IDLE) && (count < DEPTH_C);
    assign busy     = (state == ST_RUN) || (state == ST_DRAIN);
    assign in_acc   = in_valid && in_ready;

    // RUN reads element k for issue while writing back element k-1 captured from the SFU
    always_comb begin
        buf_we = 1'b0;
        buf_wa = count[AW-1:0];
        buf_wd = in_data;
        buf_ra = run_k[AW-1:0];
        case (state)
            ST_IDLE: buf_we = in_acc;
            ST_RUN: begin
                buf_we = (run_k != '0);
                buf_wa = run_k[AW-1:0] - 1'b1;
                buf_wd = sfu_y;
            end
            ST_DRAIN: buf_ra = rd[AW-1:0];
            default: ;
        endcase
    end

    sfu_vec_buf #(
        .DEPTH(DEPTH)
    ) u_buf (
        .clk    (clk),
        .we     (buf_we),
        .wr_addr(buf_wa),
        .wr_data(buf_wd),
        .rd_sel (buf_ra),
        .rd_data(buf_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            run_k     <= '0;
            rd        <= '0;
            sfu_x     <= '0;
            sfu_func  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
`ifdef SFU_ACCUM_EN
            sum_out   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_acc) begin
                        count <= count + 1'b1;
                        if (in_last || (count + 1'b1 == DEPTH_C)) begin
                            state <= ST_LOADED;
                        end
                    end
                end
                ST_LOADED: begin
                    if (cmd_start) begin
                        sfu_func <= cmd_func;
                        run_k    <= '0;
                        state    <= ST_RUN;
`ifdef SFU_ACCUM_EN
                        sum_out  <= '0;
`endif
                    end
                end
                ST_RUN: begin
                    if (run_k < count) begin
                        sfu_x <= buf_rd;
                    end
`ifdef SFU_ACCUM_EN
                    if (run_k != '0) begin
                        sum_out <= sum_out + SUM_W'(sfu_y);
                    end
`endif
                    if (run_k == count) begin
                        rd    <= '0;
                        state <= ST_DRAIN;
                    end else begin
                        run_k <= run_k + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Output register is refilled from the buffer whenever it is empty or being consumed
                    if (out_valid && out_ready && out_last) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        count     <= '0;
                        state     <= ST_IDLE;
                    end else if ((!out_valid || out_ready) && (rd < count)) begin
                        out_data  <= buf_rd;
                        out_last  <= (rd == count - 1'b1);
                        out_valid <= 1'b1;
                        rd        <= rd + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sfu_stream_driver.sv
// Scoreboard bench for sfu_stream_driver with a behavioural Q4.4 SFU model on the sfu_x/sfu_y interface.
module tb_sfu_stream_driver;
    import sfu_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [7:0]  in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_last = 1'b0;
    logic               in_ready;
    logic               cmd_start = 1'b0;
    logic [2:0]         cmd_func = '0;
    logic               busy;
    logic signed [7:0]  sfu_x;
    logic [2:0]         sfu_func;
    logic signed [7:0]  sfu_y;
    logic signed [7:0]  out_data;
    logic               out_valid;
    logic               out_last;
    logic               out_ready = 1'b1;
`ifdef SFU_ACCUM_EN
    logic signed [15:0] sum_out;
`endif

    int         pass_cnt = 0;
    int         total_cnt = 0;
    logic [8:0] exp_q[$];
    bit         rand_rdy = 1'b0;

    always #5 clk = ~clk;

    sfu_stream_driver #(.DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .cmd_start(cmd_start),
        .cmd_func (cmd_func),
        .busy     (busy),
        .sfu_x    (sfu_x),
        .sfu_func (sfu_func),
        .sfu_y    (sfu_y),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_last (out_last),
        .out_ready(out_ready)
`ifdef SFU_ACCUM_EN
        ,
        .sum_out  (sum_out)
`endif
    );

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic logic signed [7:0] sfu_model(input logic [2:0] f, input logic signed [7:0] x);
        int xi;
        int v;
        xi = x;
        case (f)
            FN_RELU, FN_GELU: v = (xi < 0) ? 0 : xi;
            FN_SIGMOID:       v = clampi(ONE / 2 + xi / 4, 0, ONE);
            FN_TANH:          v = clampi(xi, -ONE, ONE);
            FN_EXP:           v = (xi < -32) ? 0 : clampi(ONE + xi / 2, 0, 127);
            FN_RSQRT:         v = (xi <= 0) ? 127 : ONE;
            FN_IDENT:         v = xi;
            default:          v = clampi((xi < 0) ? -xi : xi, 0, 127);
        endcase
        return 8'(v);
    endfunction

    assign sfu_y = sfu_model(sfu_func, sfu_x);

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor: pops the scoreboard on each handshake and checks stall stability
    logic              prev_stall = 1'b0;
    logic signed [7:0] prev_data = '0;
    logic              prev_last = 1'b0;
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", int'({out_valid, out_last, out_data}), int'({1'b1, prev_last, prev_data}));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_out: got data %0d with nothing expected", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", int'(out_data), int'($signed(e[7:0])));
                    check("out_last", int'(out_last), int'(e[8]));
                    check("busy_in_drain", int'(busy), 1);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send(input int d, input logic l);
        bit acc = 1'b0;
        in_data  = 8'(d);
        in_valid = 1'b1;
        in_last  = l;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) check("send_accept", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic load(input int din[8], input int n, input logic use_last);
        for (int i = 0; i < n; i++) send(din[i], use_last && (i == n - 1));
    endtask

    task automatic go(input logic [2:0] f, input int dout[8], input int n, input bit expect_out);
        if (expect_out)
            for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), 8'(dout[i])});
        cmd_func  = f;
        cmd_start = 1'b1;
        @(posedge clk);
        #1;
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, int'(ok), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid(input string name);
        bit ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, int'(ok), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int din[8];
        int dout[8];

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_sfu_x", int'(sfu_x), 0);
        check("rst_sfu_func", int'(sfu_func), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // RELU on a 3-element vector
        din  = '{3, -5, 20, 0, 0, 0, 0, 0};
        dout = '{3, 0, 20, 0, 0, 0, 0, 0};
        load(din, 3, 1'b1);
        go(FN_RELU, dout, 3, 1'b1);
        wait_done("relu_done");
        @(negedge clk);
        check("relu_idle_in_ready", int'(in_ready), 1);
        check("relu_idle_busy", int'(busy), 0);
        @(posedge clk);
        #1;

        // Full buffer without in_last, extra operand refused, identity readback
        din = '{1, -1, 127, -128, 55, -77, 0, 9};
        load(din, 8, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'sd99;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_in_ready", int'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        go(FN_IDENT, din, 8, 1'b1);
        wait_done("ident_done");

        // Issue/capture alignment against nonlinear functions
        din  = '{0, 40, -40, 0, 0, 0, 0, 0};
        dout = '{8, 16, 0, 0, 0, 0, 0, 0};
        load(din, 3, 1'b1);
        go(FN_SIGMOID, dout, 3, 1'b1);
        wait_done("sigmoid_done");
        din  = '{0, -64, 0, 0, 0, 0, 0, 0};
        dout = '{16, 0, 0, 0, 0, 0, 0, 0};
        load(din, 2, 1'b1);
        go(FN_EXP, dout, 2, 1'b1);
        wait_done("exp_done");

        // Single element: out_last on first output
        din  = '{-9, 0, 0, 0, 0, 0, 0, 0};
        dout = '{9, 0, 0, 0, 0, 0, 0, 0};
        load(din, 1, 1'b1);
        go(FN_ABS, dout, 1, 1'b1);
        wait_done("single_done");

        // Random back-pressure during DRAIN
        rand_rdy = 1'b1;
        din  = '{1, -2, 30, -30, 16, -17, 0, 0};
        dout = '{1, -2, 16, -16, 16, -16, 0, 0};
        load(din, 6, 1'b1);
        go(FN_TANH, dout, 6, 1'b1);
        wait_done("backpressure_done");
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;

        // Reset in RUN cycle 2 aborts without emitting output
        din = '{10, 20, 30, 0, 0, 0, 0, 0};
        load(din, 3, 1'b1);
        go(FN_IDENT, dout, 3, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_sfu_x", int'(sfu_x), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        din  = '{-7, -128, 5, 0, 0, 0, 0, 0};
        dout = '{7, 127, 5, 0, 0, 0, 0, 0};
        load(din, 3, 1'b1);
        go(FN_ABS, dout, 3, 1'b1);
        wait_done("post_abort_done");

`ifdef SFU_ACCUM_EN
        din  = '{100, 100, -50, 0, 0, 0, 0, 0};
        load(din, 3, 1'b1);
        go(FN_IDENT, din, 3, 1'b1);
        wait_out_valid("accum_drain_entry");
        check("accum_sum_first", int'(sum_out), 150);
        wait_done("accum_done");
        check("accum_sum_hold", int'(sum_out), 150);
        din = '{1, 2, 3, 0, 0, 0, 0, 0};
        load(din, 3, 1'b1);
        go(FN_IDENT, din, 3, 1'b1);
        wait_out_valid("accum2_drain_entry");
        check("accum_sum_second", int'(sum_out), 6);
        wait_done("accum2_done");
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
